// File: rtl/sgmii_pkg.sv
// rtl/sgmii_pkg.sv - shared rate/state encodings for the SGMII transmit rate adapter
package sgmii_pkg;

    localparam logic [1:0] RATE_10M  = 2'b00;
    localparam logic [1:0] RATE_100M = 2'b01;
    localparam logic [1:0] RATE_1G   = 2'b10;

    localparam logic [7:0] IDLE_BYTE = 8'h00;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_t;

    // The reserved encoding runs at gigabit timing.
    function automatic logic [1:0] map_rate(input logic [1:0] rate);
        return (rate == 2'b11) ? RATE_1G : rate;
    endfunction

endpackage

// File: rtl/sgmii_rep_counter.sv
// rtl/sgmii_rep_counter.sv - byte replication counter, flags the last repetition
module sgmii_rep_counter
    import sgmii_pkg::*;
#(
    parameter int REP_100M = 10,
    parameter int REP_10M  = 100,
    parameter int CNT_W    = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] rate,
    output logic       last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rep_m1;

    always_comb begin
        rep_m1 = '0;
        case (rate)
            RATE_10M:  rep_m1 = CNT_W'(REP_10M - 1);
            RATE_100M: rep_m1 = CNT_W'(REP_100M - 1);
            default:   rep_m1 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= rep_m1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sgmii_tx_rate_adapt.sv
// rtl/sgmii_tx_rate_adapt.sv - GMII-to-PCS transmit rate adapter (1G/100M/10M byte replication)
// Optional statistics counters enabled by SGMII_TX_RATE_ADAPT_STATS_EN.
module sgmii_tx_rate_adapt
    import sgmii_pkg::*;
#(
    parameter int REP_100M = 10,
    parameter int REP_10M  = 100,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  operational_rate,
    input  logic [7:0]  in_data,
    input  logic        in_en,
    input  logic        in_er,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_en,
    output logic        out_er,
    output logic [1:0]  rate_active,
    output logic        underrun
`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  underrun_count
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic       ready_en;
    logic       cnt_last;
    logic       xfer;
    logic       starve;
    logic       sample_rate;
    logic [1:0] rate_eff;

    // Held low through reset and the first cycle after it, so in_ready reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign in_ready    = ready_en & cnt_last;
    assign xfer        = in_valid & in_ready;
    assign starve      = in_ready & ~in_valid & (state == ST_FRAME);
    assign sample_rate = (state == ST_IDLE) & cnt_last;
    // A frame-starting byte must use the rate sampled on its own accept cycle.
    assign rate_eff    = sample_rate ? map_rate(operational_rate) : rate_active;

    sgmii_rep_counter #(
        .REP_100M (REP_100M),
        .REP_10M  (REP_10M),
        .CNT_W    (CNT_W)
    ) u_rep_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (xfer | starve),
        .rate  (rate_eff),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            if (state == ST_IDLE && in_en)       state_nxt = ST_FRAME;
            else if (state == ST_FRAME && !in_en) state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= IDLE_BYTE;
            out_en      <= 1'b0;
            out_er      <= 1'b0;
            rate_active <= RATE_1G;
            underrun    <= 1'b0;
        end else begin
            underrun <= starve;
            if (sample_rate) rate_active <= map_rate(operational_rate);
            if (xfer) begin
                out_data <= in_data;
                out_en   <= in_en;
                out_er   <= in_er;
            end else if (starve) begin
                out_data <= IDLE_BYTE;
                out_en   <= 1'b1;
                out_er   <= 1'b1;
            end else if (sample_rate) begin
                out_data <= IDLE_BYTE;
                out_en   <= 1'b0;
                out_er   <= 1'b0;
            end
        end
    end

`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count    <= 16'h0000;
            underrun_count <= 8'h00;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_FRAME) frame_count <= frame_count + 16'h0001;
            if (starve && underrun_count != 8'hFF)        underrun_count <= underrun_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_sgmii_tx_rate_adapt.sv
// tb/tb_sgmii_tx_rate_adapt.sv - self-checking bench for sgmii_tx_rate_adapt
`timescale 1ns/1ps
module tb_sgmii_tx_rate_adapt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  operational_rate;
    logic [7:0]  in_data;
    logic        in_en;
    logic        in_er;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_en;
    logic        out_er;
    logic [1:0]  rate_active;
    logic        underrun;
`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  underrun_count;
`endif

    int total = 0;
    int bad   = 0;

    always #4 clk = ~clk;

    sgmii_tx_rate_adapt dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .operational_rate (operational_rate),
        .in_data          (in_data),
        .in_en            (in_en),
        .in_er            (in_er),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_en           (out_en),
        .out_er           (out_er),
        .rate_active      (rate_active),
        .underrun         (underrun)
`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
        ,
        .frame_count      (frame_count),
        .underrun_count   (underrun_count)
`endif
    );

    typedef struct {
        logic       valid;
        logic       en;
        logic       er;
        logic [7:0] data;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic       exp_en;
        logic       exp_er;
        logic       exp_ur;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic v, input logic e, input logic r, input logic [7:0] d,
                                input logic xr, input logic [7:0] xd, input logic xe,
                                input logic xer, input logic xu);
        vec_t t;
        t.valid = v; t.en = e; t.er = r; t.data = d;
        t.exp_ready = xr; t.exp_data = xd; t.exp_en = xe; t.exp_er = xer; t.exp_ur = xu;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte on a last-repetition cycle, then check it is held for rep cycles.
    task automatic xfer_byte(input logic [7:0] d, input logic en, input logic er, input int rep);
        check("ready_at_accept", in_ready, 1);
        in_data  = d;
        in_en    = en;
        in_er    = er;
        in_valid = 1'b1;
        step();
        for (int k = 0; k < rep; k++) begin
            check("hold_data", out_data, d);
            check("hold_en", out_en, en);
            check("hold_er", out_er, er);
            check("hold_underrun", underrun, 0);
            check("hold_ready", in_ready, (k == rep - 1));
            if (k < rep - 1) step();
        end
    endtask

    task automatic starve_slot(input int rep);
        check("ready_at_starve", in_ready, 1);
        in_valid = 1'b0;
        step();
        for (int k = 0; k < rep; k++) begin
            check("ur_data", out_data, 8'h00);
            check("ur_en", out_en, 1);
            check("ur_er", out_er, 1);
            check("ur_pulse", underrun, (k == 0));
            check("ur_ready", in_ready, (k == rep - 1));
            if (k < rep - 1) step();
        end
    endtask

    initial begin
        vecs[0] = mk(1, 1, 0, 8'hAA, 1, 8'hAA, 1, 0, 0);
        vecs[1] = mk(1, 1, 1, 8'hBB, 1, 8'hBB, 1, 1, 0);
        vecs[2] = mk(0, 1, 0, 8'h11, 1, 8'h00, 1, 1, 1);
        vecs[3] = mk(1, 1, 0, 8'hCC, 1, 8'hCC, 1, 0, 0);
        vecs[4] = mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        vecs[5] = mk(0, 1, 0, 8'h22, 1, 8'h00, 0, 0, 0);
        vecs[6] = mk(1, 0, 1, 8'h0F, 1, 8'h0F, 0, 1, 0);
        vecs[7] = mk(0, 0, 0, 8'h33, 1, 8'h00, 0, 0, 0);

        rst_n = 1'b0;
        operational_rate = 2'b11;
        in_data = 8'h00; in_en = 1'b0; in_er = 1'b0; in_valid = 1'b0;
        step();
        step();
        check("rst_data", out_data, 8'h00);
        check("rst_en", out_en, 0);
        check("rst_er", out_er, 0);
        check("rst_ready", in_ready, 0);
        check("rst_rate", rate_active, 2'b10);
        check("rst_underrun", underrun, 0);
`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
        check("rst_frame_count", frame_count, 0);
        check("rst_underrun_count", underrun_count, 0);
`endif
        rst_n = 1'b1;
        step();
        check("reserved_rate_is_1g", rate_active, 2'b10);
        check("ready_after_reset", in_ready, 1);

        // Reserved rate runs at gigabit timing: every vector is a one-cycle pipeline.
        for (int i = 0; i < 8; i++) begin
            in_valid = vecs[i].valid;
            in_en    = vecs[i].en;
            in_er    = vecs[i].er;
            in_data  = vecs[i].data;
            check("vec_ready", in_ready, vecs[i].exp_ready);
            step();
            check("vec_data", out_data, vecs[i].exp_data);
            check("vec_en", out_en, vecs[i].exp_en);
            check("vec_er", out_er, vecs[i].exp_er);
            check("vec_underrun", underrun, vecs[i].exp_ur);
        end

        // 1G 64-byte frame; rate request changes to 100M halfway but must not take effect.
        operational_rate = 2'b10;
        for (int i = 0; i < 64; i++) begin
            xfer_byte(8'(i * 3 + 1), 1'b1, 1'b0, 1);
            if (i == 32) operational_rate = 2'b01;
        end
        check("rate_frozen_in_frame", rate_active, 2'b10);
        xfer_byte(8'h00, 1'b0, 1'b0, 1);
        check("rate_frozen_at_end_byte", rate_active, 2'b10);
`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
        check("frame_count_1g", frame_count, 2);
`endif

        // 100M frame, one starved slot, then a 10M request that waits for IDLE.
        xfer_byte(8'h55, 1'b1, 1'b0, 10);
        check("rate_100m", rate_active, 2'b01);
        operational_rate = 2'b00;
        xfer_byte(8'hD5, 1'b1, 1'b0, 10);
        xfer_byte(8'hA1, 1'b1, 1'b0, 10);
        starve_slot(10);
        xfer_byte(8'h77, 1'b1, 1'b0, 10);
        check("rate_still_100m", rate_active, 2'b01);
        xfer_byte(8'h00, 1'b0, 1'b0, 10);
`ifdef SGMII_TX_RATE_ADAPT_STATS_EN
        check("frame_count_100m", frame_count, 3);
        check("underrun_count", underrun_count, 2);
`endif

        // 10M single byte held 100 cycles, then reset mid-frame.
        xfer_byte(8'h3C, 1'b1, 1'b0, 100);
        check("rate_10m", rate_active, 2'b00);
        rst_n = 1'b0;
        #1;
        check("midrst_en", out_en, 0);
        check("midrst_data", out_data, 8'h00);
        check("midrst_ready", in_ready, 0);
        check("midrst_rate", rate_active, 2'b10);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", in_ready, 1);
        step();
        check("post_rst_idle_en", out_en, 0);
        check("post_rst_no_underrun", underrun, 0);
        check("post_rst_rate", rate_active, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
